// File: rtl/dds_da_pkg.sv
// Shared definitions for the multi-channel DDS: mode and register encodings,
// gain format, and the gain saturation helper.
package dds_da_pkg;

  typedef enum logic [1:0] {
    MODE_SINE = 2'd0,
    MODE_OOK  = 2'd1,
    MODE_BPSK = 2'd2,
    MODE_MUTE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    REG_STEP      = 2'd0,
    REG_PHASE_OFS = 2'd1,
    REG_GAIN      = 2'd2,
    REG_MODE      = 2'd3
  } reg_addr_e;

  localparam int GAIN_W     = 9;
  localparam int GAIN_UNITY = 256;

  // Gain is Q1.8; anything above unity clips to unity so the scaler never overflows.
  function automatic logic [GAIN_W-1:0] sat_gain(input logic [31:0] value);
    return (value > 32'(GAIN_UNITY)) ? GAIN_W'(GAIN_UNITY) : value[GAIN_W-1:0];
  endfunction

endpackage

// File: rtl/dds_da_channel.sv
// One DDS channel: phase accumulator, ROM address stage, control delay line
// aligned to the ROM latency, and the gain scaler feeding the DA register.
module dds_da_channel
  import dds_da_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int ADDR_W  = 10,
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sync_clr,
  input  logic [PHASE_W-1:0] step,
  input  logic [ADDR_W-1:0]  phase_ofs,
  input  logic [GAIN_W-1:0]  gain,
  input  logic [1:0]         mode,
  input  logic               mod_bit,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  da_data
);

  localparam logic [DATA_W-1:0] MID  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] HALF = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam int PW = DATA_W + GAIN_W + 2;

  logic [PHASE_W-1:0] acc;
  logic [ADDR_W-1:0]  bpsk_ofs;
  logic [1:0]         mode_q1, mode_q2;
  logic [GAIN_W-1:0]  gain_q1, gain_q2;
  logic               bit_q1, bit_q2;
  logic signed [DATA_W:0] diff;
  logic [DATA_W-1:0]  scaled;
  logic [DATA_W-1:0]  sample;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (sync_clr) begin
      acc <= '0;
    end else begin
      acc <= acc + step;
    end
  end

  assign bpsk_ofs = (mode == MODE_BPSK && mod_bit) ? HALF : '0;

  // Controls travel with their address through the one-cycle ROM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      mode_q1  <= MODE_SINE;
      mode_q2  <= MODE_SINE;
      gain_q1  <= GAIN_W'(GAIN_UNITY);
      gain_q2  <= GAIN_W'(GAIN_UNITY);
      bit_q1   <= 1'b0;
      bit_q2   <= 1'b0;
    end else begin
      rom_addr <= acc[PHASE_W-1 -: ADDR_W] + phase_ofs + bpsk_ofs;
      mode_q1  <= mode;
      mode_q2  <= mode_q1;
      gain_q1  <= gain;
      gain_q2  <= gain_q1;
      bit_q1   <= mod_bit;
      bit_q2   <= bit_q1;
    end
  end

  // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
  always_comb begin
    diff   = $signed({1'b0, rom_data}) - $signed({1'b0, MID});
    scaled = DATA_W'(((PW'(diff) * PW'($signed({1'b0, gain_q2}))) >>> 8)
                     + PW'($signed({1'b0, MID})));
    sample = scaled;
    if (mode_q2 == MODE_MUTE || (mode_q2 == MODE_OOK && !bit_q2)) begin
      sample = MID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      da_data <= MID;
    end else begin
      da_data <= sample;
    end
  end

endmodule

// File: rtl/dds_multi_da.sv
// Multi-channel DDS top: shadow/active configuration banks with atomic commit,
// per-channel generators, pipeline-fill valid flag and the inverted DA clock.
module dds_multi_da
  import dds_da_pkg::*;
#(
  parameter int                 CH_NUM   = 2,
  parameter int                 DATA_W   = 10,
  parameter int                 ADDR_W   = 10,
  parameter int                 PHASE_W  = 32,
  parameter logic [PHASE_W-1:0] DEF_STEP = PHASE_W'(32'd4194304)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [2:0]                 cfg_ch,
  input  logic [1:0]                 cfg_addr,
  input  logic [31:0]                cfg_wdata,
  input  logic                       cfg_commit,
  input  logic                       sync_clr,
  input  logic [CH_NUM-1:0]          bit_in,
  output logic [CH_NUM*ADDR_W-1:0]   rom_addr,
  input  logic [CH_NUM*DATA_W-1:0]   rom_data,
  output logic                       da_clk,
  output logic [CH_NUM*DATA_W-1:0]   da_data,
  output logic                       da_valid
);

  logic [PHASE_W-1:0] step_sh [CH_NUM];
  logic [PHASE_W-1:0] step_nx [CH_NUM];
  logic [PHASE_W-1:0] step_act[CH_NUM];
  logic [ADDR_W-1:0]  ofs_sh  [CH_NUM];
  logic [ADDR_W-1:0]  ofs_nx  [CH_NUM];
  logic [ADDR_W-1:0]  ofs_act [CH_NUM];
  logic [GAIN_W-1:0]  gain_sh [CH_NUM];
  logic [GAIN_W-1:0]  gain_nx [CH_NUM];
  logic [GAIN_W-1:0]  gain_act[CH_NUM];
  logic [1:0]         mode_sh [CH_NUM];
  logic [1:0]         mode_nx [CH_NUM];
  logic [1:0]         mode_act[CH_NUM];
  logic [2:0]         fill;

  // Next shadow values include this cycle's write, so a coincident commit picks it up.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      step_nx[k] = step_sh[k];
      ofs_nx[k]  = ofs_sh[k];
      gain_nx[k] = gain_sh[k];
      mode_nx[k] = mode_sh[k];
      if (cfg_we && cfg_ch == 3'(k)) begin
        case (reg_addr_e'(cfg_addr))
          REG_STEP:      step_nx[k] = PHASE_W'(cfg_wdata);
          REG_PHASE_OFS: ofs_nx[k]  = cfg_wdata[ADDR_W-1:0];
          REG_GAIN:      gain_nx[k] = sat_gain(cfg_wdata);
          REG_MODE:      mode_nx[k] = cfg_wdata[1:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH_NUM; k++) begin
        step_sh[k]  <= DEF_STEP;
        step_act[k] <= DEF_STEP;
        ofs_sh[k]   <= '0;
        ofs_act[k]  <= '0;
        gain_sh[k]  <= GAIN_W'(GAIN_UNITY);
        gain_act[k] <= GAIN_W'(GAIN_UNITY);
        mode_sh[k]  <= MODE_SINE;
        mode_act[k] <= MODE_SINE;
      end
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        step_sh[k] <= step_nx[k];
        ofs_sh[k]  <= ofs_nx[k];
        gain_sh[k] <= gain_nx[k];
        mode_sh[k] <= mode_nx[k];
        if (cfg_commit) begin
          step_act[k] <= step_nx[k];
          ofs_act[k]  <= ofs_nx[k];
          gain_act[k] <= gain_nx[k];
          mode_act[k] <= mode_nx[k];
        end
      end
    end
  end

  // Three stages (accumulator, address, DA) must fill before samples are meaningful.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else begin
      fill <= {fill[1:0], 1'b1};
    end
  end

  assign da_valid = fill[2];
  assign da_clk   = ~clk;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    dds_da_channel #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .PHASE_W (PHASE_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sync_clr  (sync_clr),
      .step      (step_act[g]),
      .phase_ofs (ofs_act[g]),
      .gain      (gain_act[g]),
      .mode      (mode_act[g]),
      .mod_bit   (bit_in[g]),
      .rom_addr  (rom_addr[g*ADDR_W +: ADDR_W]),
      .rom_data  (rom_data[g*DATA_W +: DATA_W]),
      .da_data   (da_data[g*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_dds_multi_da.sv
// Directed bench for dds_multi_da with two channels and an identity ROM
// (rom_data = rom_addr, one-cycle latency).
module tb_dds_multi_da;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_ch = '0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_commit = 1'b0;
  logic        sync_clr = 1'b0;
  logic [1:0]  bit_in = '0;
  logic [19:0] rom_addr;
  logic [19:0] rom_data;
  logic        da_clk;
  logic [19:0] da_data;
  logic        da_valid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_addr;

  dds_multi_da #(
    .CH_NUM   (2),
    .DATA_W   (10),
    .ADDR_W   (10),
    .PHASE_W  (32),
    .DEF_STEP (32'd4194304)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_commit (cfg_commit),
    .sync_clr   (sync_clr),
    .bit_in     (bit_in),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .da_clk     (da_clk),
    .da_data    (da_data),
    .da_valid   (da_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int addr, input logic [31:0] data,
                           input logic commit);
    cfg_we     = 1'b1;
    cfg_ch     = 3'(ch);
    cfg_addr   = 2'(addr);
    cfg_wdata  = data;
    cfg_commit = commit;
    tick();
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic pulse(input logic commit, input logic clr);
    cfg_commit = commit;
    sync_clr   = clr;
    tick();
    cfg_commit = 1'b0;
    sync_clr   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if (da_data !== {10'd512, 10'd512}) begin
      bad++; $display("FAIL reset_da got=%h want=%h", da_data, {10'd512, 10'd512});
    end
    total++;
    if (rom_addr !== 20'd0) begin
      bad++; $display("FAIL reset_addr got=%h want=0", rom_addr);
    end
    total++;
    if (da_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", da_valid);
    end
    total++;
    if (da_clk !== ~clk) begin
      bad++; $display("FAIL da_clk got=%b want=%b", da_clk, ~clk);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (da_valid !== 1'b0) begin
      bad++; $display("FAIL valid_edge1 got=%b want=0", da_valid);
    end
    tick();
    total++;
    if (da_valid !== 1'b0) begin
      bad++; $display("FAIL valid_edge2 got=%b want=0", da_valid);
    end
    tick();
    total++;
    if (da_valid !== 1'b1) begin
      bad++; $display("FAIL valid_edge3 got=%b want=1", da_valid);
    end
    total++;
    if (rom_addr !== {10'd2, 10'd2}) begin
      bad++; $display("FAIL reset_ramp_addr got=%h want=%h", rom_addr, {10'd2, 10'd2});
    end
  endtask

  task automatic test_ramp();
    logic [9:0] ea;
    logic [9:0] ed;
    pulse(1'b0, 1'b1);
    for (int j = 1; j <= 1030; j++) begin
      tick();
      ea = 10'((j - 1) % 1024);
      total++;
      if (rom_addr !== {ea, ea}) begin
        bad++; $display("FAIL ramp_addr j=%0d got=%h want=%h", j, rom_addr, {ea, ea});
      end
      if (j >= 3) begin
        ed = 10'((j - 3) % 1024);
        total++;
        if (da_data !== {ed, ed}) begin
          bad++; $display("FAIL ramp_da j=%0d got=%h want=%h", j, da_data, {ed, ed});
        end
      end
    end
  endtask

  task automatic test_gain();
    cfg_write(0, 0, 32'd0, 1'b0);
    cfg_write(0, 1, 32'd1023, 1'b0);
    cfg_write(0, 2, 32'd128, 1'b0);
    pulse(1'b1, 1'b1);
    repeat (4) tick();
    total++;
    if (rom_addr !== {10'd3, 10'd1023}) begin
      bad++; $display("FAIL gain_addr got=%h want=%h", rom_addr, {10'd3, 10'd1023});
    end
    total++;
    if (da_data !== {10'd1, 10'd767}) begin
      bad++; $display("FAIL gain128_hi got=%h want=%h", da_data, {10'd1, 10'd767});
    end
    cfg_write(0, 1, 32'd0, 1'b1);
    tick();
    total++;
    if (rom_addr[9:0] !== 10'd0) begin
      bad++; $display("FAIL ofs_commit_addr got=%0d want=0", rom_addr[9:0]);
    end
    tick();
    total++;
    if (da_data[9:0] !== 10'd767) begin
      bad++; $display("FAIL commit_latency got=%0d want=767", da_data[9:0]);
    end
    tick();
    total++;
    if (da_data[9:0] !== 10'd256) begin
      bad++; $display("FAIL gain128_lo got=%0d want=256", da_data[9:0]);
    end
    cfg_write(0, 2, 32'd300, 1'b1);
    cfg_write(0, 1, 32'd1023, 1'b1);
    repeat (4) tick();
    total++;
    if (da_data[9:0] !== 10'd1023) begin
      bad++; $display("FAIL gain_sat got=%0d want=1023", da_data[9:0]);
    end
  endtask

  task automatic test_modes();
    cfg_write(0, 3, 32'd2, 1'b0);
    cfg_write(0, 1, 32'd600, 1'b0);
    cfg_write(1, 3, 32'd1, 1'b0);
    cfg_write(1, 0, 32'd0, 1'b0);
    cfg_write(1, 1, 32'd100, 1'b0);
    bit_in = 2'b01;
    pulse(1'b1, 1'b1);
    repeat (4) tick();
    total++;
    if (rom_addr !== {10'd100, 10'd88}) begin
      bad++; $display("FAIL bpsk_addr got=%h want=%h", rom_addr, {10'd100, 10'd88});
    end
    total++;
    if (da_data !== {10'd512, 10'd88}) begin
      bad++; $display("FAIL ook0_bpsk1 got=%h want=%h", da_data, {10'd512, 10'd88});
    end
    bit_in = 2'b10;
    repeat (4) tick();
    total++;
    if (rom_addr !== {10'd100, 10'd600}) begin
      bad++; $display("FAIL bpsk0_addr got=%h want=%h", rom_addr, {10'd100, 10'd600});
    end
    total++;
    if (da_data !== {10'd100, 10'd600}) begin
      bad++; $display("FAIL ook1_bpsk0 got=%h want=%h", da_data, {10'd100, 10'd600});
    end
    cfg_write(1, 3, 32'd3, 1'b1);
    repeat (4) tick();
    total++;
    if (da_data[19:10] !== 10'd512) begin
      bad++; $display("FAIL mute got=%0d want=512", da_data[19:10]);
    end
  endtask

  task automatic test_commit();
    cfg_write(0, 3, 32'd0, 1'b0);
    cfg_write(0, 0, 32'd4194304, 1'b0);
    cfg_write(0, 1, 32'd5, 1'b0);
    cfg_write(1, 3, 32'd0, 1'b0);
    cfg_write(1, 0, 32'd4194304, 1'b0);
    cfg_write(1, 1, 32'd9, 1'b0);
    pulse(1'b1, 1'b1);
    cfg_write(1, 0, 32'd8388608, 1'b0);
    repeat (3) tick();
    total++;
    if (rom_addr !== {10'd12, 10'd8}) begin
      bad++; $display("FAIL no_commit got=%h want=%h", rom_addr, {10'd12, 10'd8});
    end
    pulse(1'b1, 1'b0);
    total++;
    if (rom_addr !== {10'd13, 10'd9}) begin
      bad++; $display("FAIL commit_e0 got=%h want=%h", rom_addr, {10'd13, 10'd9});
    end
    tick();
    total++;
    if (rom_addr !== {10'd14, 10'd10}) begin
      bad++; $display("FAIL commit_e1 got=%h want=%h", rom_addr, {10'd14, 10'd10});
    end
    tick();
    total++;
    if (rom_addr !== {10'd16, 10'd11}) begin
      bad++; $display("FAIL commit_e2 got=%h want=%h", rom_addr, {10'd16, 10'd11});
    end
    tick();
    total++;
    if (rom_addr !== {10'd18, 10'd12}) begin
      bad++; $display("FAIL commit_e3 got=%h want=%h", rom_addr, {10'd18, 10'd12});
    end
    total++;
    if (da_data !== {10'd14, 10'd10}) begin
      bad++; $display("FAIL commit_da got=%h want=%h", da_data, {10'd14, 10'd10});
    end
    pulse(1'b0, 1'b1);
    tick();
    total++;
    if (rom_addr !== {10'd9, 10'd5}) begin
      bad++; $display("FAIL sync_addr got=%h want=%h", rom_addr, {10'd9, 10'd5});
    end
    total++;
    if (da_valid !== 1'b1) begin
      bad++; $display("FAIL sync_valid got=%b want=1", da_valid);
    end
  endtask

  task automatic test_mid_reset();
    cfg_write(0, 3, 32'd3, 1'b0);
    cfg_write(1, 2, 32'd128, 1'b0);
    repeat (3) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (da_data !== {10'd512, 10'd512}) begin
      bad++; $display("FAIL async_da got=%h want=%h", da_data, {10'd512, 10'd512});
    end
    total++;
    if (rom_addr !== 20'd0) begin
      bad++; $display("FAIL async_addr got=%h want=0", rom_addr);
    end
    total++;
    if (da_valid !== 1'b0) begin
      bad++; $display("FAIL async_valid got=%b want=0", da_valid);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    total++;
    if (rom_addr !== {10'd2, 10'd2} || da_valid !== 1'b1) begin
      bad++; $display("FAIL rerun got=%h/%b want=%h/1", rom_addr, da_valid, {10'd2, 10'd2});
    end
    pulse(1'b1, 1'b1);
    repeat (4) tick();
    total++;
    if (rom_addr !== {10'd3, 10'd3}) begin
      bad++; $display("FAIL def_regs_addr got=%h want=%h", rom_addr, {10'd3, 10'd3});
    end
    total++;
    if (da_data !== {10'd1, 10'd1}) begin
      bad++; $display("FAIL def_regs_da got=%h want=%h", da_data, {10'd1, 10'd1});
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gain();
    test_modes();
    test_commit();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_multi_da.md
# dds_multi_da

Parametrised multi-channel DDS waveform generator driving parallel offset-binary DA converters. It is the successor to the single-step sine sender: each channel has a phase accumulator, a phase offset, a gain, and a modulation mode (sine, OOK, BPSK, mute). Each channel has its own sine ROM port and bit-stream input. Configuration is written into shadow registers and applied to all channels atomically on a commit pulse, so channels stay phase-coherent.

## Interface
Parameters:
- CH_NUM, 2, number of DA channels (1-8)
- DATA_W, 10, DA / ROM sample width, offset binary
- ADDR_W, 10, ROM address width (ROM depth 2^ADDR_W)
- PHASE_W, 32, phase accumulator width (must be >= ADDR_W)
- DEF_STEP, 32'd4194304, reset tuning word for every channel

Ports:
- clk  in  1  sample clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  shadow register write strobe
- cfg_ch  in  3  target channel; values >= CH_NUM are ignored
- cfg_addr  in  2  register select: 0 STEP, 1 PHASE_OFS, 2 GAIN, 3 MODE
- cfg_wdata  in  32  write data, LSB-aligned
- cfg_commit  in  1  copy all shadow registers to the active registers
- sync_clr  in  1  clear every phase accumulator
- bit_in  in  CH_NUM  per-channel modulation bit
- rom_addr  out  CH_NUM*ADDR_W  per-channel ROM address, registered
- rom_data  in  CH_NUM*DATA_W  per-channel ROM data; 1-cycle read latency
- da_clk  out  1  ~clk (DA latches on the rising edge of da_clk)
- da_data  out  CH_NUM*DATA_W  per-channel DA sample, registered; channel k at [k*DATA_W +: DATA_W]
- da_valid  out  1  high once the pipeline has filled after reset

## Operation
- Registers per channel, shadow and active copies:
  - STEP: PHASE_W bits, reset DEF_STEP.
  - PHASE_OFS: ADDR_W bits, reset 0.
  - GAIN: 9 bits, reset 256. A written value > 256 saturates to 256.
  - MODE: 2 bits, reset 0.
- A write updates the shadow copy only.
- cfg_commit loads active <= shadow for all channels. If a write and a commit occur in the same cycle, the commit includes that write.
- Accumulator: acc <= acc + STEP each cycle, modulo 2^PHASE_W. STEP = 0 holds the phase.
- Address: rom_addr <= acc[PHASE_W-1 -: ADDR_W] + PHASE_OFS + (MODE==BPSK && bit ? 2^(ADDR_W-1) : 0), modulo 2^ADDR_W.
- Mode encoding: 0 SINE, 1 OOK, 2 BPSK, 3 MUTE.
- Sample selection:
  - OOK with bit = 0 outputs MID = 2^(DATA_W-1).
  - MUTE always outputs MID.
  - All other cases output the scaled ROM sample.
- Scaling: d = sample - MID (signed, DATA_W+1 bits); out = MID + ((d*GAIN) >>> 8), arithmetic shift. With GAIN <= 256 the result always lies in [0, 2^DATA_W-1]; no clamp is needed.
- Pipeline alignment: bit_in, MODE, and GAIN are registered alongside the address they modulate, so each sample uses the settings in force when its address was formed.
- sync_clr: acc <= 0 on all channels. If sync_clr and commit coincide, both take effect; the accumulator restarts at 0 using the new STEP.

## Timing
- Reset values: acc 0, rom_addr 0, da_data MID on every channel, da_valid 0, active and shadow registers at their reset values. da_clk follows ~clk regardless of reset.
- Commit at edge n: new STEP is added at edge n+1. New PHASE_OFS/MODE/GAIN affect rom_addr at n+1 and da_data at n+3.
- Latency: rom_addr at edge t, rom_data valid during cycle t+1, da_data registered at edge t+2.
- sync_clr at edge n: acc = 0 after n; rom_addr = PHASE_OFS after n+1; the corresponding sample appears after n+3.
- da_valid rises 3 edges after reset release and stays high; sync_clr does not deassert it.
- Reset asserted mid-operation returns every output to its reset value immediately (asynchronously).

## Structure
- Package dds_da_pkg holds:
  - mode encodings MODE_SINE/OOK/BPSK/MUTE;
  - register addresses REG_STEP/PHASE_OFS/GAIN/MODE;
  - GAIN_UNITY = 256.
- Sub-module dds_da_channel is instantiated CH_NUM times in a generate loop. It contains the accumulator, the address stage, the delay registers for aligned controls, and the scaler.
- The top level holds the shadow/active register banks, cfg decode, commit logic, and da_clk.

## Test plan
All scenarios use CH_NUM=2, DATA_W=10, ADDR_W=10, PHASE_W=32, and an identity ROM model (rom_data = rom_addr, 1-cycle latency).
- Reset: hold rst_n low → da_data = {512,512}, rom_addr = {0,0}, da_valid = 0. Release → da_valid = 1 at the 3rd edge.
- Ramp: STEP = 2^22 on both channels, gain 256, SINE → rom_addr increments by 1 per clk and wraps 1023→0; da_data equals rom_addr delayed by 2 clks.
- Gain: ch0 GAIN = 128 → sample 1023 gives 767 and sample 0 gives 256. Writing GAIN = 300 behaves as 256.
- Modes: ch1 OOK with bit_in[1] = 0 → 512, with bit = 1 → ramp. ch0 BPSK with bit = 1 → rom_addr offset by +512 (addr 600 → 88).
- Commit: write ch1 STEP = 2^23 without commit → output unchanged. Pulse cfg_commit → both channels switch on the same edge. sync_clr → rom_addr = PHASE_OFS on both channels one edge later.
- Mid-run reset: assert rst_n low while ramping → outputs return to reset values immediately; registers return to DEF_STEP, 0, 256, SINE.
